// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V controller: states, mux selects, opcodes.
package riscv_ctrl_pkg;

  localparam int unsigned OP_W    = 7;
  localparam int unsigned STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_JALRPC   = 4'd12,
    S_LUI      = 4'd13,
    S_AUIPC    = 4'd14,
    S_TRAP     = 4'd15
  } state_t;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_A     = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_WDATA = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [OP_W-1:0] OP_LW    = 7'b0000011;
  localparam logic [OP_W-1:0] OP_SW    = 7'b0100011;
  localparam logic [OP_W-1:0] OP_RTYPE = 7'b0110011;
  localparam logic [OP_W-1:0] OP_ITYPE = 7'b0010011;
  localparam logic [OP_W-1:0] OP_BEQ   = 7'b1100011;
  localparam logic [OP_W-1:0] OP_JAL   = 7'b1101111;
  localparam logic [OP_W-1:0] OP_JALR  = 7'b1100111;
  localparam logic [OP_W-1:0] OP_LUI   = 7'b0110111;
  localparam logic [OP_W-1:0] OP_AUIPC = 7'b0010111;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle: opcode/status in, enables and selects out.
interface multicycle_ctrl_if;
  import riscv_ctrl_pkg::*;

  logic [OP_W-1:0]    op;
  logic               Zero;
  logic               MemReady;
  logic               PCWrite;
  logic               IRWrite;
  logic               MemWrite;
  logic               RegWrite;
  logic               AdrSrc;
  logic [1:0]         ResultSrc;
  logic [1:0]         ALUSrcA;
  logic [1:0]         ALUSrcB;
  logic [1:0]         ALUOp;
  logic [2:0]         ImmSrc;
  logic [STATE_W-1:0] State;
  logic               Illegal;

  modport master (
    input  op, Zero, MemReady,
    output PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc,
           ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, State, Illegal
  );

  modport slave (
    output op, Zero, MemReady,
    input  PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc,
           ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, State, Illegal
  );
endinterface

// File: rtl/mc_output_decode.sv
// Moore output decode of the controller state; PCWrite/IRWrite also see Zero/MemReady.
module mc_output_decode
  import riscv_ctrl_pkg::*;
(
  input  state_t          State,
  input  logic [OP_W-1:0] op,
  input  logic            Zero,
  input  logic            MemReady,
  input  logic            reset,
  output logic            PCWrite,
  output logic            IRWrite,
  output logic            MemWrite,
  output logic            RegWrite,
  output logic            AdrSrc,
  output logic [1:0]      ResultSrc,
  output logic [1:0]      ALUSrcA,
  output logic [1:0]      ALUSrcB,
  output logic [1:0]      ALUOp,
  output logic [2:0]      ImmSrc,
  output logic            Illegal
);

  // Per-state control word; reset kills every enable and the trap flag.
  always_comb begin
    PCWrite   = 1'b0;
    IRWrite   = 1'b0;
    MemWrite  = 1'b0;
    RegWrite  = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_WDATA;
    ALUOp     = ALUOP_ADD;
    ImmSrc    = IMM_I;
    Illegal   = 1'b0;
    case (State)
      S_FETCH: begin
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        IRWrite   = MemReady;
        PCWrite   = MemReady;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        if (op == OP_BEQ)      ImmSrc = IMM_B;
        else if (op == OP_JAL) ImmSrc = IMM_J;
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_A;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = (op == OP_SW) ? IMM_S : IMM_I;
      end
      S_MEMREAD:  AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = SRCA_A;
        ALUOp   = ALUOP_FUNCT;
      end
      S_EXECI: begin
        ALUSrcA = SRCA_A;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALUOP_FUNCT;
      end
      S_ALUWB:    RegWrite = 1'b1;
      S_BEQ: begin
        ALUSrcA = SRCA_A;
        ALUOp   = ALUOP_SUB;
        PCWrite = Zero;
      end
      S_JAL, S_JALRPC: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_FOUR;
        PCWrite = 1'b1;
      end
      S_JALR: begin
        ALUSrcA = SRCA_A;
        ALUSrcB = SRCB_IMM;
      end
      S_LUI: begin
        ALUSrcA = SRCA_ZERO;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = IMM_U;
      end
      S_AUIPC: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = IMM_U;
      end
      S_TRAP:     Illegal = 1'b1;
      default: ;
    endcase
    if (reset) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
      Illegal  = 1'b0;
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V main controller: state register and next-state logic.
module multicycle_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned USE_MEM_READY = 1
) (
  input  logic               clk,
  input  logic               reset,
  multicycle_ctrl_if.master  bus
);

  state_t state;
  state_t stateNext;
  logic   memReady;

  assign memReady  = (USE_MEM_READY != 0) ? bus.MemReady : 1'b1;
  assign bus.State = state;

  // State register with synchronous reset back to FETCH.
  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= stateNext;
  end

  // Next-state: memory states wait on MemReady, DECODE dispatches on opcode.
  always_comb begin
    stateNext = state;
    case (state)
      S_FETCH:    stateNext = memReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: stateNext = S_MEMADR;
          OP_RTYPE:     stateNext = S_EXECR;
          OP_ITYPE:     stateNext = S_EXECI;
          OP_BEQ:       stateNext = S_BEQ;
          OP_JAL:       stateNext = S_JAL;
          OP_JALR:      stateNext = S_JALR;
          OP_LUI:       stateNext = S_LUI;
          OP_AUIPC:     stateNext = S_AUIPC;
          default:      stateNext = S_TRAP;
        endcase
      end
      S_MEMADR:   stateNext = (bus.op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  stateNext = memReady ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    stateNext = S_FETCH;
      S_MEMWRITE: stateNext = memReady ? S_FETCH : S_MEMWRITE;
      S_EXECR, S_EXECI, S_JAL, S_JALRPC, S_LUI, S_AUIPC:
                  stateNext = S_ALUWB;
      S_ALUWB:    stateNext = S_FETCH;
      S_BEQ:      stateNext = S_FETCH;
      S_JALR:     stateNext = S_JALRPC;
      S_TRAP:     stateNext = S_TRAP;
      default:    stateNext = S_FETCH;
    endcase
  end

  mc_output_decode u_decode (
    .State     (state),
    .op        (bus.op),
    .Zero      (bus.Zero),
    .MemReady  (memReady),
    .reset     (reset),
    .PCWrite   (bus.PCWrite),
    .IRWrite   (bus.IRWrite),
    .MemWrite  (bus.MemWrite),
    .RegWrite  (bus.RegWrite),
    .AdrSrc    (bus.AdrSrc),
    .ResultSrc (bus.ResultSrc),
    .ALUSrcA   (bus.ALUSrcA),
    .ALUSrcB   (bus.ALUSrcB),
    .ALUOp     (bus.ALUOp),
    .ImmSrc    (bus.ImmSrc),
    .Illegal   (bus.Illegal)
  );

endmodule
